// File: rtl/timer_pkg.sv
// Shared definitions for the stopwatch core: start-mode encodings, BCD constants,
// controller state type and the per-digit preset clamp.
package timer_pkg;

    localparam logic [1:0] MODE_UP0 = 2'b00;
    localparam logic [1:0] MODE_UPP = 2'b01;
    localparam logic [1:0] MODE_DN9 = 2'b10;
    localparam logic [1:0] MODE_DNP = 2'b11;

    localparam logic [3:0] BCD_NINE = 4'd9;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } sw_state_e;

    // Non-decimal nibbles load as zero so the counter never holds an illegal digit.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] nib);
        return (nib > BCD_NINE) ? 4'd0 : nib;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch counter: loadable, steps up or down when enabled and the
// lower digits ripple a carry (up) or borrow (down) into it.
module bcd_digit
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       dir_down,
    input  logic       carry_in,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] value,
    output logic       carry_out,
    output logic       is_terminal
);

    logic [3:0] value_q, value_d;
    logic       step;

    assign step = en & carry_in;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (step) begin
            if (dir_down) begin
                value_d = (value_q == 4'd0) ? BCD_NINE : value_q - 4'd1;
            end else begin
                value_d = (value_q == BCD_NINE) ? 4'd0 : value_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign is_terminal = dir_down ? (value_q == 4'd0) : (value_q == BCD_NINE);
    assign carry_out   = step & is_terminal;
    assign value       = value_q;

endmodule

// File: rtl/bcd_stopwatch_core.sv
// N-digit BCD stopwatch/countdown engine with prescaled tick, start/stop and lap buttons,
// terminal-count flag and optional wrap-around.
module bcd_stopwatch_core
    import timer_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 1000000,
    parameter int unsigned WRAP     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic [4*DIGITS-1:0]   preset,
    input  logic                  load,
    input  logic                  start_stop,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  running,
    output logic                  lap_held,
    output logic                  done
);

    localparam int unsigned CW      = 4 * DIGITS;
    localparam int unsigned PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic WRAP_EN        = (WRAP != 0);

    // Reset asserts asynchronously and releases on the clock.
    logic [1:0] rst_sync_q;
    logic       rst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst = rst_sync_q[1];

    // Button synchronisers: [0] metastable stage, [1] synced level, [2] previous level.
    logic [2:0] ss_q, lap_q;
    logic       ss_edge, lap_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q  <= 3'b000;
            lap_q <= 3'b000;
        end else begin
            ss_q  <= {ss_q[1:0], start_stop};
            lap_q <= {lap_q[1:0], lap};
        end
    end

    assign ss_edge  = ss_q[1] & ~ss_q[2];
    assign lap_edge = lap_q[1] & ~lap_q[2];

    sw_state_e       state_q, state_d;
    logic            dir_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic            wrap_pulse_q;
    logic            lap_held_q, lap_held_d;
    logic [CW-1:0]   lap_reg_q, lap_reg_d;
    logic [CW-1:0]   count_bcd_q;
    logic [CW-1:0]   count_q;
    logic [DIGITS-1:0] carry, cin, term;
    logic            tick, step_en, all_term, upper_term, near_term, finish, wrap_evt;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] start_nib;

        always_comb begin
            case (mode)
                MODE_UP0: start_nib = 4'd0;
                MODE_DN9: start_nib = BCD_NINE;
                default:  start_nib = clamp_bcd(preset[4*i +: 4]);
            endcase
        end

        if (i == 0) begin : g_lsd
            assign cin[i] = 1'b1;
        end else begin : g_upper
            assign cin[i] = carry[i-1];
        end

        bcd_digit u_digit (
            .clk        (clk),
            .reset      (rst),
            .en         (step_en),
            .dir_down   (dir_q),
            .carry_in   (cin[i]),
            .load       (load),
            .load_val   (start_nib),
            .value      (count_q[4*i +: 4]),
            .carry_out  (carry[i]),
            .is_terminal(term[i])
        );
    end

    always_comb begin
        upper_term = 1'b1;
        for (int unsigned i = 1; i < DIGITS; i++) begin
            upper_term = upper_term & term[i];
        end
    end

    // near_term: one step away from terminal (99..98 up, 00..01 down).
    assign all_term  = upper_term & term[0];
    assign near_term = upper_term & (count_q[3:0] == (dir_q ? 4'd1 : 4'd8));
    assign tick      = (state_q == StRun) && (presc_q == PRE_MAX);
    assign step_en   = tick & (WRAP_EN | ~all_term);
    assign finish    = tick & ~WRAP_EN & (all_term | near_term);
    assign wrap_evt  = WRAP_EN & carry[DIGITS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Tick resolves before a coincident start/stop edge; a finished count ignores starts.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (ss_edge) state_d = StRun;
                StRun: begin
                    if (finish) begin
                        state_d = StDone;
                    end else if (ss_edge) begin
                        state_d = StIdle;
                    end
                end
                StDone:  state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        running = (state_q == StRun);
        done    = (state_q == StDone) | wrap_pulse_q;
    end

    always_comb begin
        presc_d = presc_q;
        if (load) begin
            presc_d = '0;
        end else if (state_q != StRun) begin
            if (state_d == StRun) presc_d = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    always_comb begin
        lap_held_d = lap_held_q;
        lap_reg_d  = lap_reg_q;
        if (load) begin
            lap_held_d = 1'b0;
        end else if (lap_edge) begin
            if (!lap_held_q) begin
                lap_reg_d  = count_q;
                lap_held_d = 1'b1;
            end else begin
                lap_held_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q        <= 1'b0;
            presc_q      <= '0;
            wrap_pulse_q <= 1'b0;
            lap_held_q   <= 1'b0;
            lap_reg_q    <= '0;
            count_bcd_q  <= '0;
        end else begin
            if (load) dir_q <= mode[1];
            presc_q      <= presc_d;
            wrap_pulse_q <= ~load & wrap_evt;
            lap_held_q   <= lap_held_d;
            lap_reg_q    <= lap_reg_d;
            count_bcd_q  <= lap_held_q ? lap_reg_q : count_q;
        end
    end

    assign count_bcd = count_bcd_q;
    assign lap_held  = lap_held_q;

endmodule
